// File: rtl/pe_stream_feeder.sv
// Stream sequencer for one PE: fetches filter/ifmap/ipsum words from a 1-cycle-latency
// buffer port, feeds them over valid/ready, and writes opsums back. Option: PE_STREAM_FEEDER_RELU_EN.

module pe_feed_fifo #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  output logic [DW-1:0] dout,
  output logic          vld,
  output logic [1:0]    cnt
);
  logic [1:0][DW-1:0] mem;
  logic               wptr, rptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem  <= '0;
      wptr <= 1'b0;
      rptr <= 1'b0;
      cnt  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      cnt <= cnt + {1'b0, push} - {1'b0, pop};
    end
  end

  assign dout = mem[rptr];
  assign vld  = (cnt != 2'd0);
endmodule

module pe_stream_feeder #(
  parameter int DATA_BITS   = 32,
  parameter int ADDR_BITS   = 16,
  parameter int CONFIG_SIZE = 13
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [CONFIG_SIZE-1:0] cfg,
  input  logic [ADDR_BITS-1:0]   filter_base,
  input  logic [ADDR_BITS-1:0]   ifmap_base,
  input  logic [ADDR_BITS-1:0]   ipsum_base,
  input  logic [ADDR_BITS-1:0]   opsum_base,
  output logic                   rd_en,
  output logic [ADDR_BITS-1:0]   rd_addr,
  input  logic [DATA_BITS-1:0]   rd_data,
  output logic                   wr_en,
  output logic [ADDR_BITS-1:0]   wr_addr,
  output logic [DATA_BITS-1:0]   wr_data,
  output logic                   PE_en,
  output logic [CONFIG_SIZE-1:0] i_config,
  output logic [DATA_BITS-1:0]   filter,
  output logic [DATA_BITS-1:0]   ifmap,
  output logic [DATA_BITS-1:0]   ipsum,
  output logic                   filter_valid,
  output logic                   ifmap_valid,
  output logic                   ipsum_valid,
  input  logic                   filter_ready,
  input  logic                   ifmap_ready,
  input  logic                   ipsum_ready,
  input  logic [DATA_BITS-1:0]   opsum,
  input  logic                   opsum_valid,
  output logic                   opsum_ready,
  output logic                   busy,
  output logic                   done
);
  localparam int NS = 3;  // stream lanes: 0 filter, 1 ifmap, 2 ipsum

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CFG    = 3'd1;
  localparam logic [2:0] S_FILTER = 3'd2;
  localparam logic [2:0] S_IFMAP  = 3'd3;
  localparam logic [2:0] S_IPSUM  = 3'd4;
  localparam logic [2:0] S_OPSUM  = 3'd5;
  localparam logic [2:0] S_DONE   = 3'd6;

  logic [2:0]             state;
  logic [CONFIG_SIZE-1:0] cfg_q;
  logic [ADDR_BITS-1:0]   fil_addr, ifm_addr, ips_addr, ops_addr;
  logic [4:0]             fetch_left, hs_left, col;
  logic                   rd_pend;

  logic [4:0] rs_n, u_n, p_n, q_n, k_n, f_n, filt_n;
  assign rs_n   = {3'b0, cfg_q[11:10]} + 5'd1;
  assign u_n    = {4'b0, cfg_q[9]} + 5'd1;
  assign p_n    = {3'b0, cfg_q[8:7]} + 5'd1;
  assign f_n    = cfg_q[6:2];
  assign q_n    = {3'b0, cfg_q[1:0]} + 5'd1;
  assign k_n    = cfg_q[12] ? q_n : p_n;
  assign filt_n = p_n * rs_n;

  logic [NS-1:0]                phase_oh, fifo_push, fifo_pop, fifo_vld, fifo_rdy;
  logic [NS-1:0][DATA_BITS-1:0] fifo_head;
  logic [NS-1:0][1:0]           fifo_cnt;

  assign phase_oh  = {state == S_IPSUM, state == S_IFMAP, state == S_FILTER};
  assign fifo_rdy  = {ipsum_ready, ifmap_ready, filter_ready};
  assign fifo_pop  = fifo_vld & fifo_rdy;
  // Reads are only issued for the active phase, so the returning word always
  // belongs to the stream that is active now.
  assign fifo_push = phase_oh & {NS{rd_pend}};

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_fifo
      pe_feed_fifo #(.DW(DATA_BITS)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (fifo_push[gi]),
        .din  (rd_data),
        .pop  (fifo_pop[gi]),
        .dout (fifo_head[gi]),
        .vld  (fifo_vld[gi]),
        .cnt  (fifo_cnt[gi])
      );
    end
  endgenerate

  logic [1:0]           cur_cnt;
  logic                 cur_pop;
  logic [2:0]           credit_use;
  logic [ADDR_BITS-1:0] cur_addr;

  always_comb begin
    cur_cnt  = 2'd0;
    cur_addr = '0;
    case (state)
      S_FILTER: begin cur_cnt = fifo_cnt[0]; cur_addr = fil_addr; end
      S_IFMAP:  begin cur_cnt = fifo_cnt[1]; cur_addr = ifm_addr; end
      S_IPSUM:  begin cur_cnt = fifo_cnt[2]; cur_addr = ips_addr; end
      default:  ;
    endcase
  end

  // A word popped this cycle frees its slot for a read issued this cycle,
  // which keeps a stream at one word per cycle while ready stays high.
  assign cur_pop    = |(fifo_pop & phase_oh);
  assign credit_use = {1'b0, cur_cnt} + {2'b0, rd_pend} - {2'b0, cur_pop};
  assign rd_en      = (|phase_oh) && (fetch_left != 5'd0) && (credit_use < 3'd2);
  assign rd_addr    = rd_en ? cur_addr : '0;

  logic opsum_hs, phase_hs, last_hs;
  assign opsum_ready = (state == S_OPSUM);
  assign opsum_hs    = opsum_valid && opsum_ready;
  assign phase_hs    = (|fifo_pop) || opsum_hs;
  assign last_hs     = phase_hs && (hs_left == 5'd1);

  logic [DATA_BITS-1:0] wb_data;
`ifdef PE_STREAM_FEEDER_RELU_EN
  assign wb_data = opsum[DATA_BITS-1] ? '0 : opsum;
`else
  assign wb_data = opsum;
`endif
  assign wr_en   = opsum_hs;
  assign wr_addr = ops_addr;
  assign wr_data = opsum_hs ? wb_data : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_q      <= '0;
      fil_addr   <= '0;
      ifm_addr   <= '0;
      ips_addr   <= '0;
      ops_addr   <= '0;
      fetch_left <= 5'd0;
      hs_left    <= 5'd0;
      col        <= 5'd0;
      rd_pend    <= 1'b0;
    end else begin
      rd_pend <= rd_en;
      if (rd_en) begin
        fetch_left <= fetch_left - 5'd1;
        case (state)
          S_FILTER: fil_addr <= fil_addr + 1'b1;
          S_IFMAP:  ifm_addr <= ifm_addr + 1'b1;
          S_IPSUM:  ips_addr <= ips_addr + 1'b1;
          default:  ;
        endcase
      end
      if (phase_hs) hs_left <= hs_left - 5'd1;
      if (opsum_hs) ops_addr <= ops_addr + 1'b1;

      // Phase loads below override the decrements above on the last handshake.
      case (state)
        S_IDLE: if (start) begin
          state    <= S_CFG;
          cfg_q    <= cfg;
          fil_addr <= filter_base;
          ifm_addr <= ifmap_base;
          ips_addr <= ipsum_base;
          ops_addr <= opsum_base;
        end
        S_CFG: begin
          state      <= S_FILTER;
          fetch_left <= filt_n;
          hs_left    <= filt_n;
          col        <= 5'd0;
        end
        S_FILTER: if (last_hs) begin
          state      <= S_IFMAP;
          fetch_left <= rs_n;
          hs_left    <= rs_n;
        end
        S_IFMAP: if (last_hs) begin
          state      <= S_IPSUM;
          fetch_left <= k_n;
          hs_left    <= k_n;
        end
        S_IPSUM: if (last_hs) begin
          state      <= S_OPSUM;
          fetch_left <= 5'd0;
          hs_left    <= k_n;
        end
        S_OPSUM: if (last_hs) begin
          if (col == f_n) begin
            state <= S_DONE;
          end else begin
            state      <= S_IFMAP;
            col        <= col + 5'd1;
            fetch_left <= u_n;
            hs_left    <= u_n;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign i_config     = cfg_q;
  assign PE_en        = (state == S_CFG);
  assign busy         = (state != S_IDLE);
  assign done         = (state == S_DONE);
  assign filter       = fifo_head[0];
  assign ifmap        = fifo_head[1];
  assign ipsum        = fifo_head[2];
  assign filter_valid = fifo_vld[0];
  assign ifmap_valid  = fifo_vld[1];
  assign ipsum_valid  = fifo_vld[2];
endmodule

// File: tb/tb_pe_stream_feeder.sv
// Randomized bench for pe_stream_feeder: a queue-based model of the expected pass
// (handshake order, read addresses, write-backs) is compared every cycle.

module tb_pe_stream_feeder;
  localparam int DW = 32, AW = 16, CS = 13;
  localparam int K_CFG = 0, K_FIL = 1, K_IFM = 2, K_IPS = 3, K_OPS = 4, K_DONE = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, start;
  logic [CS-1:0] cfg;
  logic [AW-1:0] filter_base, ifmap_base, ipsum_base, opsum_base;
  logic          rd_en, wr_en, PE_en, busy, done;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [DW-1:0] rd_data, wr_data, filter, ifmap, ipsum, opsum;
  logic [CS-1:0] i_config;
  logic          filter_valid, ifmap_valid, ipsum_valid;
  logic          filter_ready, ifmap_ready, ipsum_ready;
  logic          opsum_valid, opsum_ready;

  pe_stream_feeder dut (
    .clk(clk), .rst(rst), .start(start), .cfg(cfg),
    .filter_base(filter_base), .ifmap_base(ifmap_base),
    .ipsum_base(ipsum_base), .opsum_base(opsum_base),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .PE_en(PE_en), .i_config(i_config),
    .filter(filter), .ifmap(ifmap), .ipsum(ipsum),
    .filter_valid(filter_valid), .ifmap_valid(ifmap_valid), .ipsum_valid(ipsum_valid),
    .filter_ready(filter_ready), .ifmap_ready(ifmap_ready), .ipsum_ready(ipsum_ready),
    .opsum(opsum), .opsum_valid(opsum_valid), .opsum_ready(opsum_ready),
    .busy(busy), .done(done)
  );

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
    int            col;
  } ev_t;

  ev_t           hsq[$];
  ev_t           rdq[$];
  logic [DW-1:0] ovr[$];
  logic [DW-1:0] o_wr_dat[$];
  int            n_chk = 0, n_pass = 0;
  int            mode = 0, mid_at = -1;
  logic [CS-1:0] pass_cfg;
  bit            pend;
  logic [AW-1:0] pend_addr;
  logic [2:0]    pv_vld, pv_rdy, pv_hs;
  logic [2:0][DW-1:0] pv_dat;
  int            o_fil, o_ifm, o_ips, o_wr, o_done;
  int            o_ifm_col[32];
  logic [AW-1:0] o_last_wr, o_last_ifm;

  function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a);
    return {a ^ 16'hC3A5, ~a};
  endfunction

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] x);
`ifdef PE_STREAM_FEEDER_RELU_EN
    return x[DW-1] ? '0 : x;
`else
    return x;
`endif
  endfunction

  task automatic chk(input bit ok, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic chk_eq(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    chk(act === exp, name, act, exp);
  endtask

  // Expected pass: every handshake in order, plus every buffer read in order.
  task automatic build(input logic [CS-1:0] c, input logic [AW-1:0] fb, ib, pb, ob);
    int p, q, rs, u, f, k;
    logic [AW-1:0] ia, pa, oa;
    ev_t e;
    p = int'(c[8:7]) + 1; q = int'(c[1:0]) + 1; rs = int'(c[11:10]) + 1;
    u = int'(c[9]) + 1;   f = int'(c[6:2]);     k = c[12] ? q : p;
    pass_cfg = c;
    e = '{K_CFG, '0, '0, 0}; hsq.push_back(e);
    for (int i = 0; i < p * rs; i++) begin
      e = '{K_FIL, fb + AW'(i), mem_word(fb + AW'(i)), 0};
      hsq.push_back(e); rdq.push_back(e);
    end
    ia = ib; pa = pb; oa = ob;
    for (int cl = 0; cl <= f; cl++) begin
      for (int i = 0; i < ((cl == 0) ? rs : u); i++) begin
        e = '{K_IFM, ia, mem_word(ia), cl}; hsq.push_back(e); rdq.push_back(e); ia++;
      end
      for (int i = 0; i < k; i++) begin
        e = '{K_IPS, pa, mem_word(pa), cl}; hsq.push_back(e); rdq.push_back(e); pa++;
      end
      for (int i = 0; i < k; i++) begin
        e = '{K_OPS, oa, '0, cl}; hsq.push_back(e); oa++;
      end
    end
    e = '{K_DONE, '0, '0, 0}; hsq.push_back(e);
  endtask

  task automatic clear_obs();
    o_fil = 0; o_ifm = 0; o_ips = 0; o_wr = 0; o_done = 0;
    o_last_wr = '0; o_last_ifm = '0; o_wr_dat.delete();
    for (int i = 0; i < 32; i++) o_ifm_col[i] = 0;
  endtask

  task automatic step(input bit do_start);
    int fk;
    logic [2:0] vld, rdy;
    logic [2:0][DW-1:0] dat;
    @(negedge clk);
    start = do_start;
    case (mode)
      0: begin filter_ready = 1; ifmap_ready = 1; ipsum_ready = 1; opsum_valid = 1; end
      1: begin filter_ready = 1; ifmap_ready = ~ifmap_ready; ipsum_ready = 1; opsum_valid = 1; end
      default: begin
        filter_ready = ($urandom_range(0, 3) != 0);
        ifmap_ready  = ($urandom_range(0, 3) != 0);
        ipsum_ready  = ($urandom_range(0, 3) != 0);
        opsum_valid  = ($urandom_range(0, 3) != 0);
      end
    endcase
    opsum   = (ovr.size() != 0) ? ovr[0] : $urandom;
    rd_data = pend ? mem_word(pend_addr) : $urandom;
    #1;
    fk  = (hsq.size() != 0) ? hsq[0].kind : -1;
    vld = {ipsum_valid, ifmap_valid, filter_valid};
    rdy = {ipsum_ready, ifmap_ready, filter_ready};
    dat = {ipsum, ifmap, filter};
    chk_eq("busy", busy, hsq.size() != 0);
    chk_eq("pe_en", PE_en, fk == K_CFG);
    if (hsq.size() != 0) chk_eq("i_config", i_config, pass_cfg);
    chk_eq("done", done, fk == K_DONE);
    chk_eq("opsum_ready", opsum_ready, fk == K_OPS);
    chk_eq("wr_en", wr_en, opsum_valid && fk == K_OPS);
    for (int s = 0; s < 3; s++) begin
      bit hs;
      hs = 0;
      if (vld[s]) chk(fk == s + 1, "valid_phase", s, fk);
      if (pv_vld[s] && !pv_rdy[s])
        chk(vld[s] && dat[s] === pv_dat[s], "stall_hold", dat[s], pv_dat[s]);
      if (mode == 0 && pv_hs[s] && fk == s + 1) chk(vld[s], "rate", vld[s], 1);
      if (vld[s] && rdy[s] && fk == s + 1) begin
        chk_eq("stream_data", dat[s], hsq[0].val);
        if (s == 0) o_fil++;
        if (s == 1) begin o_ifm++; o_ifm_col[hsq[0].col]++; end
        if (s == 2) o_ips++;
        hs = 1;
        void'(hsq.pop_front());
      end
      pv_vld[s] = vld[s]; pv_rdy[s] = rdy[s]; pv_dat[s] = dat[s]; pv_hs[s] = hs;
    end
    if (wr_en && fk == K_OPS) begin
      chk_eq("wr_addr", wr_addr, hsq[0].addr);
      chk_eq("wr_data", wr_data, relu(opsum));
      o_wr++; o_last_wr = wr_addr; o_wr_dat.push_back(wr_data);
      void'(hsq.pop_front());
      if (ovr.size() != 0) void'(ovr.pop_front());
    end
    if (PE_en && fk == K_CFG) void'(hsq.pop_front());
    if (done && fk == K_DONE) begin o_done++; void'(hsq.pop_front()); end
    pend = rd_en;
    pend_addr = rd_addr;
    if (rd_en) begin
      bit ok;
      ok = (rdq.size() != 0) && (rdq[0].kind == fk);
      chk(ok, "rd_phase", fk, (rdq.size() != 0) ? rdq[0].kind : -1);
      if (ok) begin
        chk_eq("rd_addr", rd_addr, rdq[0].addr);
        if (rdq[0].kind == K_IFM) o_last_ifm = rd_addr;
        void'(rdq.pop_front());
      end
    end
    if (do_start && hsq.size() == 0) build(cfg, filter_base, ifmap_base, ipsum_base, opsum_base);
  endtask

  task automatic model_clear();
    hsq.delete(); rdq.delete(); ovr.delete();
    pend = 0; pv_vld = '0; pv_rdy = '0; pv_hs = '0; pv_dat = '0;
  endtask

  task automatic check_zero(input string name);
    bit z;
    z = !(rd_en | wr_en | PE_en | busy | done | filter_valid | ifmap_valid | ipsum_valid | opsum_ready)
        && rd_addr == 0 && wr_addr == 0 && wr_data == 0 && i_config == 0
        && filter == 0 && ifmap == 0 && ipsum == 0;
    chk(z, name, {busy, rd_en, wr_en, PE_en, done, filter_valid, ifmap_valid, ipsum_valid}, 0);
  endtask

  task automatic do_reset();
    rst = 1; #1;
    check_zero("rst_async_zero");
    @(posedge clk); #1;
    check_zero("rst_edge_zero");
    model_clear();
    @(negedge clk); rst = 0;
  endtask

  task automatic begin_pass(input logic [CS-1:0] c, input logic [AW-1:0] fb, ib, pb, ob, input int m);
    clear_obs();
    mode = m; cfg = c;
    filter_base = fb; ifmap_base = ib; ipsum_base = pb; opsum_base = ob;
    step(1);
  endtask

  task automatic finish_pass();
    int b;
    b = 0;
    while (hsq.size() != 0 && b < 4000) begin
      if (b == mid_at) begin
        cfg = CS'($urandom); filter_base = AW'($urandom); ifmap_base = AW'($urandom);
        ipsum_base = AW'($urandom); opsum_base = AW'($urandom);
        step(1);
      end else step(0);
      b++;
    end
    if (hsq.size() != 0) begin
      chk(0, "timeout", hsq.size(), 0);
      do_reset();
    end
    step(0); step(0);
  endtask

  initial begin
    rst = 1; start = 0; cfg = '0;
    filter_base = '0; ifmap_base = '0; ipsum_base = '0; opsum_base = '0;
    rd_data = '0; opsum = '0; opsum_valid = 0;
    filter_ready = 0; ifmap_ready = 0; ipsum_ready = 0;
    model_clear(); clear_obs();
    repeat (2) @(negedge clk);
    #1 check_zero("reset_state");
    @(negedge clk); rst = 0;

    // p=2 q=3 rs=3 U=1 F=2, all ready
    begin_pass(13'h088A, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0); finish_pass();
    chk_eq("t1_filter", o_fil, 6); chk_eq("t1_ifmap", o_ifm, 5);
    chk_eq("t1_ifm_c0", o_ifm_col[0], 3); chk_eq("t1_ifm_c1", o_ifm_col[1], 1);
    chk_eq("t1_ifm_c2", o_ifm_col[2], 1); chk_eq("t1_ipsum", o_ips, 6);
    chk_eq("t1_opsum", o_wr, 6); chk_eq("t1_last_wr", o_last_wr, 16'h0405);
    chk_eq("t1_done", o_done, 1);

    // same cfg, ifmap_ready toggling
    begin_pass(13'h088A, 16'h1000, 16'h2000, 16'h3000, 16'h4000, 1); finish_pass();
    chk_eq("t2_ifmap", o_ifm, 5); chk_eq("t2_done", o_done, 1);

    // depthwise q=4 p=1 rs=3 F=0
    begin_pass(13'h1803, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 2); finish_pass();
    chk_eq("t3_filter", o_fil, 3); chk_eq("t3_ifmap", o_ifm, 3);
    chk_eq("t3_ipsum", o_ips, 4); chk_eq("t3_opsum", o_wr, 4); chk_eq("t3_done", o_done, 1);

    // U=2 rs=3 F=3, ifmap addresses wrap past 16'hFFFF
    begin_pass(13'h0A0C, 16'h0500, 16'hFFFC, 16'h0600, 16'h0700, 2); finish_pass();
    chk_eq("t4_c0", o_ifm_col[0], 3); chk_eq("t4_c1", o_ifm_col[1], 2);
    chk_eq("t4_c2", o_ifm_col[2], 2); chk_eq("t4_c3", o_ifm_col[3], 2);
    chk_eq("t4_ifmap", o_ifm, 9); chk_eq("t4_last_ifm", o_last_ifm, 16'h0004);

    // reset during IPSUM of column 1, then a fresh full pass
    begin_pass(13'h088A, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 2);
    for (int b = 0; b < 2000 && !(hsq.size() != 0 && hsq[0].kind == K_IPS && hsq[0].col == 1); b++)
      step(0);
    chk(hsq.size() != 0 && hsq[0].kind == K_IPS, "reach_ipsum_c1", hsq.size(), 1);
    do_reset();
    begin_pass(13'h088A, 16'h0100, 16'h0200, 16'h0300, 16'h0400, 0); finish_pass();
    chk_eq("t5_opsum", o_wr, 6); chk_eq("t5_last_wr", o_last_wr, 16'h0405);
    chk_eq("t5_done", o_done, 1);

    // write-back of a negative then a positive opsum
    ovr.push_back(32'hFFFF_FFF0); ovr.push_back(32'h0000_0010);
    begin_pass(13'h1803, 16'h0010, 16'h0020, 16'h0030, 16'h0040, 0); finish_pass();
`ifdef PE_STREAM_FEEDER_RELU_EN
    chk_eq("relu_wr0", o_wr_dat[0], 32'h0);
`else
    chk_eq("relu_wr0", o_wr_dat[0], 32'hFFFF_FFF0);
`endif
    chk_eq("relu_wr1", o_wr_dat[1], 32'h10);

    // random passes, some with a start pulse while busy
    for (int r = 0; r < 8; r++) begin
      mid_at = (r % 2 == 0) ? int'($urandom_range(1, 30)) : -1;
      begin_pass(CS'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), 2);
      finish_pass();
      chk_eq("rand_done", o_done, 1);
    end
    mid_at = -1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/pe_stream_feeder.md
Name: pe_stream_feeder

Overview:
- Drives one PE's filter, ifmap and ipsum valid/ready streams, and drains its opsum stream.
- Fetches 32-bit packed words, four int8 lanes each, from a local buffer read port with 1-cycle latency. Writes opsums back through a buffer write port.
- Sits between the GLB slice and one PE. Sequences one full PE pass: config, filter, then (F+1) output columns.

Parameters:
- DATA_BITS, 32, width of stream words and buffer data.
- ADDR_BITS, 16, buffer word-address width.
- CONFIG_SIZE, 13, PE config width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- start  in  1  one-cycle pulse; ignored unless IDLE
- cfg  in  CONFIG_SIZE  PE config: [12] depthwise, [11:10] rs-1, [9] U-1, [8:7] p-1, [6:2] F, [1:0] q-1
- filter_base, ifmap_base, ipsum_base, opsum_base  in  ADDR_BITS each  word base addresses, sampled on start
- rd_en  out  1  buffer read strobe
- rd_addr  out  ADDR_BITS  read address
- rd_data  in  DATA_BITS  valid the cycle after rd_en
- wr_en  out  1  buffer write strobe (always accepted)
- wr_addr  out  ADDR_BITS  write address
- wr_data  out  DATA_BITS  write data
- PE_en  out  1  one-cycle config strobe to PE
- i_config  out  CONFIG_SIZE  config to PE, held for the whole pass
- filter / ifmap / ipsum  out  DATA_BITS each  stream data
- filter_valid / ifmap_valid / ipsum_valid  out  1 each  stream valid
- filter_ready / ifmap_ready / ipsum_ready  in  1 each  stream ready from PE
- opsum  in  DATA_BITS  opsum from PE
- opsum_valid  in  1  opsum valid from PE
- opsum_ready  out  1  opsum ready to PE
- busy  out  1  high from start until done
- done  out  1  one-cycle pulse at pass end

Behaviour:
- Reset: all outputs 0, including i_config, the fetch FIFO and all counters. State goes to IDLE. Reset mid-pass abandons the pass immediately.
- Derived values: P=p field+1, Q=q field+1, RS=rs field+1, U=U field+1. K=Q if depthwise, else P.
- Word counts:
  - filter: P*RS words.
  - ifmap: RS words for column 0, then U words for each later column.
  - ipsum: K words per column.
  - opsum: K words per column.
  - columns: F+1.
- States:
  - IDLE: start -> CFG.
  - CFG: one cycle; PE_en=1 and i_config=cfg -> FILTER.
  - FILTER: after last filter handshake -> IFMAP.
  - IFMAP: after last ifmap handshake of the column -> IPSUM.
  - IPSUM: after K handshakes -> OPSUM.
  - OPSUM: after K accepted opsums, if column==F -> DONE, else column+1 -> IFMAP.
  - DONE: done=1 for one cycle -> IDLE.
- Fetch path:
  - 2-entry FIFO per stream.
  - rd_en issues only when (FIFO occupancy + in-flight) < 2 and words remain for the current phase.
  - rd_data is pushed the cycle after rd_en.
  - Stream valid = FIFO non-empty; stream data = FIFO head. Only the current phase's valid may be high.
  - Pop on valid&&ready. Sustained rate is 1 word/cycle when ready stays high.
- Addressing:
  - filter: filter_base+i.
  - ifmap: one continuous counter from ifmap_base across all columns (RS+F*U words total).
  - ipsum and opsum: continuous counters from their bases across columns (K*(F+1) words each).
  - Address arithmetic wraps modulo 2^ADDR_BITS.
- Opsum path:
  - opsum_ready=1 only in OPSUM.
  - On opsum_valid&&opsum_ready: wr_en=1 and wr_data=opsum in the same cycle (combinational); wr_addr increments.
- Boundaries:
  - Ready low stalls the stream; data and valid are held stable.
  - A handshake on the last word ends the phase the next cycle with no extra valid cycle.
  - No read is issued past a phase's word count.
  - start during busy is ignored.
  - F=0 runs exactly one column.
- busy=1 in all states except IDLE.

Optional Feature:
- Macro PE_STREAM_FEEDER_RELU_EN.
  - Defined: wr_data = 0 when opsum[DATA_BITS-1]=1, else opsum (signed ReLU on write-back).
  - Undefined: wr_data = opsum unmodified.
- Handshakes and timing are identical either way.

Test Plan:
- cfg p=2,q=3,rs=3,U=1,F=2, non-depthwise, all readies high -> 6 filter words, ifmap 3/1/1, 2 ipsum and 2 opsum per column. wr_addr runs opsum_base..+5; one done pulse.
- Same cfg with ifmap_ready toggled 1-0 each cycle -> no lost or duplicated words; ifmap data stable while valid&&!ready; total 5 ifmap words.
- depthwise=1, q=4, p=1, rs=3, F=0 -> 3 filter words, 3 ifmap words, 4 ipsum words, 4 opsums written, done.
- U=2, rs=3, F=3 -> ifmap word counts 3,2,2,2 at sequential addresses ifmap_base..+8.
- rst asserted during IPSUM of column 1 -> all outputs 0 next edge; a fresh start then runs a full correct pass.
- Macro defined, opsum=32'hFFFF_FFF0 then 32'h0000_0010 -> wr_data 0 then 32'h10; macro undefined -> wr_data 32'hFFFF_FFF0 then 32'h10.
